// File: rtl/flash_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : flash_rd_arbiter_if
// Description : Bus bundle between two Wishbone read requesters, the flash
//               read arbiter and the parallel NOR flash pads.
// Revision    : 1.0 - initial release
// ============================================================================
interface flash_rd_arbiter_if;
  // Requester 0 (CPU / boot path)
  logic        m0_cyc_i;
  logic        m0_stb_i;
  logic        m0_we_i;
  logic [21:0] m0_adr_i;
  logic [15:0] m0_dat_o;
  logic        m0_ack_o;
  // Requester 1 (secondary master)
  logic        m1_cyc_i;
  logic        m1_stb_i;
  logic        m1_we_i;
  logic [21:0] m1_adr_i;
  logic [15:0] m1_dat_o;
  logic        m1_ack_o;
  // Flash pads
  logic [21:0] flash_addr;
  logic [15:0] flash_data;
  logic        flash_ce_n;
  logic        flash_oe_n;
  logic        flash_we_n;
  logic        flash_rst_n;

  // Arbiter side
  modport slave (
    input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i,
    output m0_dat_o, m0_ack_o,
    input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i,
    output m1_dat_o, m1_ack_o,
    output flash_addr, flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n,
    input  flash_data
  );

  // Requester side
  modport master (
    output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i,
    input  m0_dat_o, m0_ack_o,
    output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i,
    input  m1_dat_o, m1_ack_o
  );
endinterface
`default_nettype wire

// File: rtl/flash_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flash_rd_arbiter
// Description : Round-robin arbiter sharing a parallel NOR flash between two
//               Wishbone read requesters. Generates the power-up flash reset,
//               programmable CE/OE wait states, data capture and a single
//               cycle ack. Writes are acked without touching the pads.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_rd_arbiter #(
  parameter int WAIT_CYCLES = 4,
  parameter int RST_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  flash_rd_arbiter_if.slave   bus,
  output logic                busy_o
);

  localparam logic [2:0] c_st_init   = 3'd0;
  localparam logic [2:0] c_st_idle   = 3'd1;
  localparam logic [2:0] c_st_access = 3'd2;
  localparam logic [2:0] c_st_done   = 3'd3;
  localparam logic [2:0] c_st_wack   = 3'd4;

  localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rst_last  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;
  logic             r_gnt;
  logic             r_flash_rst_n;
  logic [21:0]      r_flash_addr;
  logic [15:0]      r_m0_dat;
  logic [15:0]      r_m1_dat;

  logic             w_req0;
  logic             w_req1;
  logic             w_gnt_valid;
  logic             w_gnt_id;
  logic             w_gnt_we;
  logic [21:0]      w_gnt_adr;
  logic             w_wait_end;
  logic             w_rst_end;

  assign w_req0     = bus.m0_cyc_i & bus.m0_stb_i;
  assign w_req1     = bus.m1_cyc_i & bus.m1_stb_i;
  assign w_wait_end = (r_cnt == c_wait_last);
  assign w_rst_end  = (r_cnt == c_rst_last);

  // Round-robin winner: on contention the requester not served last wins
  always_comb begin
    w_gnt_valid = w_req0 | w_req1;
    w_gnt_id    = 1'b0;
    if (w_req0 && w_req1) begin
      w_gnt_id = ~r_last_grant;
    end else if (w_req1) begin
      w_gnt_id = 1'b1;
    end
    w_gnt_we  = w_gnt_id ? bus.m1_we_i  : bus.m0_we_i;
    w_gnt_adr = w_gnt_id ? bus.m1_adr_i : bus.m0_adr_i;
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= c_st_init;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_init:   if (w_rst_end)   w_next_state = c_st_idle;
      c_st_idle:   if (w_gnt_valid) w_next_state = w_gnt_we ? c_st_wack : c_st_access;
      c_st_access: if (w_wait_end)  w_next_state = c_st_done;
      c_st_done:   w_next_state = c_st_idle;
      c_st_wack:   w_next_state = c_st_idle;
      default:     w_next_state = c_st_init;
    endcase
  end

  // Counter, grant bookkeeping, pad address, flash reset and read data capture
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_cnt         <= '0;
      r_last_grant  <= 1'b1;
      r_gnt         <= 1'b0;
      r_flash_rst_n <= 1'b0;
      r_flash_addr  <= '0;
      r_m0_dat      <= '0;
      r_m1_dat      <= '0;
    end else begin
      case (r_state)
        c_st_init: begin
          r_cnt <= r_cnt + c_cnt_one;
          if (w_rst_end) begin
            r_flash_rst_n <= 1'b1;
            r_cnt         <= '0;
          end
        end
        c_st_idle: begin
          if (w_gnt_valid) begin
            r_last_grant <= w_gnt_id;
            r_gnt        <= w_gnt_id;
            // Pads and counter are only touched for reads; writes just ack
            if (!w_gnt_we) begin
              r_flash_addr <= w_gnt_adr;
              r_cnt        <= '0;
            end
          end
        end
        c_st_access: begin
          r_cnt <= r_cnt + c_cnt_one;
          if (w_wait_end) begin
            if (r_gnt) begin
              r_m1_dat <= bus.flash_data;
            end else begin
              r_m0_dat <= bus.flash_data;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pad strobes, acks and busy decoded from the current state
  always_comb begin
    bus.flash_ce_n  = (r_state != c_st_access);
    bus.flash_oe_n  = (r_state != c_st_access);
    bus.flash_we_n  = 1'b1;
    bus.flash_rst_n = r_flash_rst_n;
    bus.flash_addr  = r_flash_addr;
    bus.m0_dat_o    = r_m0_dat;
    bus.m1_dat_o    = r_m1_dat;
    bus.m0_ack_o    = ((r_state == c_st_done) || (r_state == c_st_wack)) && !r_gnt;
    bus.m1_ack_o    = ((r_state == c_st_done) || (r_state == c_st_wack)) &&  r_gnt;
    busy_o          = (r_state != c_st_idle);
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_rd_arbiter
// Description : Directed self-checking bench for flash_rd_arbiter with a
//               simple flash model answering while CE/OE are low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_rd_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flash_rd_arbiter_if bus ();

  flash_rd_arbiter #(
    .WAIT_CYCLES (4),
    .RST_CYCLES  (32),
    .CNT_W       (6)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .bus        (bus),
    .busy_o     (busy)
  );

  // Flash contents: one marked word, everything else a fixed pattern
  function automatic logic [15:0] flash_word(input logic [21:0] a);
    if (a == 22'h12345) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Flash drives the bus only while selected and output-enabled
  always_comb begin
    bus.flash_data = (!bus.flash_ce_n && !bus.flash_oe_n) ? flash_word(bus.flash_addr) : 16'h0000;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tick until an ack appears (bounded); report ticks, who, first CE and last pad address
  task automatic wait_ack(output int n, output int who, output logic first_ce_n, output logic [21:0] seen_adr);
    n = 0;
    who = -1;
    first_ce_n = 1'b0;
    seen_adr = '0;
    while (n < 12) begin
      tick();
      n++;
      if (n == 1) first_ce_n = bus.flash_ce_n;
      if (!bus.flash_ce_n) seen_adr = bus.flash_addr;
      if (bus.m0_ack_o || bus.m1_ack_o) break;
    end
    if (bus.m0_ack_o && bus.m1_ack_o) who = 2;
    else if (bus.m0_ack_o) who = 0;
    else if (bus.m1_ack_o) who = 1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [21:0] adr);
    bus.m0_cyc_i = req;
    bus.m0_stb_i = req;
    bus.m0_we_i  = we;
    bus.m0_adr_i = adr;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [21:0] adr);
    bus.m1_cyc_i = req;
    bus.m1_stb_i = req;
    bus.m1_we_i  = we;
    bus.m1_adr_i = adr;
  endtask

  initial begin
    int n;
    int who;
    logic fce;
    logic [21:0] sadr;

    rst_n = 1'b0;
    set_m0(1'b0, 1'b0, '0);
    set_m1(1'b0, 1'b0, '0);
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_flash_rst_n", bus.flash_rst_n, 1'b0);
    chk("rst_ce_n", bus.flash_ce_n, 1'b1);
    chk("rst_oe_n", bus.flash_oe_n, 1'b1);
    chk("rst_we_n", bus.flash_we_n, 1'b1);
    chk("rst_addr", bus.flash_addr, 22'h0);
    chk("rst_ack0", bus.m0_ack_o, 1'b0);
    chk("rst_ack1", bus.m1_ack_o, 1'b0);
    chk("rst_dat0", bus.m0_dat_o, 16'h0);
    chk("rst_dat1", bus.m1_dat_o, 16'h0);
    chk("rst_busy", busy, 1'b1);

    // Release with an m0 read already pending; INIT must not ack it
    set_m0(1'b1, 1'b0, 22'h12345);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      chk("init_flash_rst_n", bus.flash_rst_n, (k == 32) ? 1'b1 : 1'b0);
      chk("init_no_ack", bus.m0_ack_o, 1'b0);
      chk("init_busy", busy, (k < 32) ? 1'b1 : 1'b0);
    end

    // m0 read of 0x12345: four access cycles then one ack
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rd0_ce_n", bus.flash_ce_n, 1'b0);
      chk("rd0_oe_n", bus.flash_oe_n, 1'b0);
      chk("rd0_addr", bus.flash_addr, 22'h12345);
      chk("rd0_early_ack", bus.m0_ack_o, 1'b0);
    end
    tick();
    chk("rd0_ack", bus.m0_ack_o, 1'b1);
    chk("rd0_ack1_quiet", bus.m1_ack_o, 1'b0);
    chk("rd0_dat", bus.m0_dat_o, 16'hBEEF);
    chk("rd0_ce_high_done", bus.flash_ce_n, 1'b1);
    set_m0(1'b0, 1'b0, '0);
    tick();
    chk("rd0_ack_single", bus.m0_ack_o, 1'b0);
    chk("rd0_idle_busy", busy, 1'b0);

    // Both request continuously; m0 was served last so m1 leads
    set_m0(1'b1, 1'b0, 22'h000010);
    set_m1(1'b1, 1'b0, 22'h3FFFF0);
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, who, fce, sadr);
      chk("rr_latency", n, (i == 0) ? 5 : 6);
      chk("rr_winner", who, (i % 2 == 0) ? 1 : 0);
      chk("rr_addr", sadr, (i % 2 == 0) ? 22'h3FFFF0 : 22'h000010);
      if (i % 2 == 0) chk("rr_dat1", bus.m1_dat_o, 16'hA5AA);
      else            chk("rr_dat0", bus.m0_dat_o, 16'h5A4A);
      if (i > 0) chk("rr_deselect", fce, 1'b1);
    end
    set_m0(1'b0, 1'b0, '0);
    set_m1(1'b0, 1'b0, '0);
    tick();

    // m1 write: acked next cycle, pads untouched, read data kept
    set_m1(1'b1, 1'b1, 22'h000003);
    tick();
    chk("wr_ack1", bus.m1_ack_o, 1'b1);
    chk("wr_ack0_quiet", bus.m0_ack_o, 1'b0);
    chk("wr_ce_n", bus.flash_ce_n, 1'b1);
    chk("wr_oe_n", bus.flash_oe_n, 1'b1);
    chk("wr_we_n", bus.flash_we_n, 1'b1);
    chk("wr_dat1_hold", bus.m1_dat_o, 16'hA5AA);
    set_m1(1'b0, 1'b0, '0);
    tick();
    chk("wr_ack_single", bus.m1_ack_o, 1'b0);
    chk("wr_idle", busy, 1'b0);

    // m0 drops stb during its access; m1 then queues a read
    set_m0(1'b1, 1'b0, 22'h02A0F0);
    tick();
    tick();
    bus.m0_stb_i = 1'b0;
    set_m1(1'b1, 1'b0, 22'h0000FF);
    wait_ack(n, who, fce, sadr);
    chk("wd_latency", n, 3);
    chk("wd_winner", who, 0);
    chk("wd_dat0", bus.m0_dat_o, 16'hFAAA);
    bus.m0_cyc_i = 1'b0;
    wait_ack(n, who, fce, sadr);
    chk("wd_m1_latency", n, 6);
    chk("wd_m1_winner", who, 1);
    chk("wd_m1_addr", sadr, 22'h0000FF);
    chk("wd_m1_dat", bus.m1_dat_o, 16'h5AA5);
    chk("wd_dat0_hold", bus.m0_dat_o, 16'hFAAA);
    set_m1(1'b0, 1'b0, '0);
    tick();

    // Reset mid-access: pads released at once, INIT reruns in full
    set_m0(1'b1, 1'b0, 22'h12345);
    tick();
    tick();
    chk("ra_in_access", bus.flash_ce_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("ra_ce_n", bus.flash_ce_n, 1'b1);
    chk("ra_oe_n", bus.flash_oe_n, 1'b1);
    chk("ra_flash_rst_n", bus.flash_rst_n, 1'b0);
    chk("ra_ack0", bus.m0_ack_o, 1'b0);
    chk("ra_busy", busy, 1'b1);
    chk("ra_addr", bus.flash_addr, 22'h0);
    set_m0(1'b0, 1'b0, '0);
    tick();
    chk("ra_held_ack0", bus.m0_ack_o, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 31) chk("ra_init_low", bus.flash_rst_n, 1'b0);
      if (k == 32) begin
        chk("ra_init_high", bus.flash_rst_n, 1'b1);
        chk("ra_idle", busy, 1'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
